// File: rtl/wrr_arbiter_if.sv
// ============================================================================
//  Module      : wrr_arbiter_if
//  Description : Request/weight/ack and grant bundle for the WRR arbiter.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface wrr_arbiter_if #(
  parameter int N            = 4,
  parameter int INDEX_WIDTH  = (N == 1) ? 1 : $clog2(N),
  parameter int WEIGHT_WIDTH = 4
);
  logic [N-1:0]                    i_request;
  logic [N-1:0][WEIGHT_WIDTH-1:0]  i_weight;
  logic                            i_ack;
  logic                            o_grant_valid;
  logic [INDEX_WIDTH-1:0]          o_grant_index;
  logic [N-1:0]                    o_grant_onehot;

  modport master (
    output i_request, i_weight, i_ack,
    input  o_grant_valid, o_grant_index, o_grant_onehot
  );

  modport slave (
    input  i_request, i_weight, i_ack,
    output o_grant_valid, o_grant_index, o_grant_onehot
  );
endinterface

`default_nettype wire

// File: rtl/wrr_arbiter.sv
// ============================================================================
//  Module      : wrr_arbiter
//  Description : Weighted round-robin arbiter; grant held for a burst of acks.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module wrr_arbiter #(
  parameter int N            = 4,
  parameter int INDEX_WIDTH  = (N == 1) ? 1 : $clog2(N),
  parameter int WEIGHT_WIDTH = 4
) (
  input  wire logic      i_clk,
  input  wire logic      i_rst_n,
  wrr_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                  state_q;
  logic                    valid_q;
  logic [INDEX_WIDTH-1:0]  index_q;
  logic [N-1:0]            onehot_q;
  logic [INDEX_WIDTH-1:0]  ptr_q;
  logic [WEIGHT_WIDTH-1:0] credit_q;

  logic                    w_any_req;
  logic                    w_hi_found;
  logic [INDEX_WIDTH-1:0]  w_hi_idx;
  logic [INDEX_WIDTH-1:0]  w_lo_idx;
  logic [INDEX_WIDTH-1:0]  w_win_idx;
  logic [WEIGHT_WIDTH-1:0] w_win_weight;
  logic [WEIGHT_WIDTH-1:0] w_win_credit;
  logic                    w_release;
  logic                    w_arb_event;

  // Descending scan: last hit is the lowest index, both overall and above the pointer.
  always_comb begin
    w_any_req  = |bus.i_request;
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.i_request[i]) begin
        w_lo_idx = INDEX_WIDTH'(i);
        if (i > int'(ptr_q)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = INDEX_WIDTH'(i);
        end
      end
    end
    w_win_idx = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  assign w_win_weight = bus.i_weight[w_win_idx];
  assign w_win_credit = (w_win_weight == '0) ? WEIGHT_WIDTH'(1) : w_win_weight;

  assign w_release   = (state_q == ST_GRANT) &&
                       ((bus.i_ack && (credit_q == WEIGHT_WIDTH'(1))) ||
                        !bus.i_request[index_q]);
  assign w_arb_event = (state_q == ST_IDLE) || w_release;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      index_q  <= '0;
      onehot_q <= '0;
      credit_q <= '0;
      ptr_q    <= INDEX_WIDTH'(N - 1);
    end else if (w_arb_event) begin
      if (w_any_req) begin
        state_q  <= ST_GRANT;
        valid_q  <= 1'b1;
        index_q  <= w_win_idx;
        onehot_q <= N'(1) << w_win_idx;
        ptr_q    <= w_win_idx;
        credit_q <= w_win_credit;
      end else begin
        state_q  <= ST_IDLE;
        valid_q  <= 1'b0;
        index_q  <= '0;
        onehot_q <= '0;
        credit_q <= '0;
      end
    end else if (bus.i_ack) begin
      // No release implies credit > 1 here, so this never reaches zero.
      credit_q <= credit_q - WEIGHT_WIDTH'(1);
    end
  end

  assign bus.o_grant_valid  = valid_q;
  assign bus.o_grant_index  = index_q;
  assign bus.o_grant_onehot = onehot_q;

endmodule

`default_nettype wire

// File: tb/tb_wrr_arbiter.sv
// ============================================================================
//  Module      : tb_wrr_arbiter
//  Description : Directed self-checking bench for wrr_arbiter (N=4).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_wrr_arbiter;

  logic i_clk;
  logic i_rst_n;
  int   n_cmp;
  int   n_err;

  wrr_arbiter_if #(.N(4), .INDEX_WIDTH(2), .WEIGHT_WIDTH(4)) bus ();

  wrr_arbiter #(.N(4), .INDEX_WIDTH(2), .WEIGHT_WIDTH(4)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n       = 1'b0;
    bus.i_request = 4'b0000;
    bus.i_ack     = 1'b0;
    bus.i_weight  = {4'd1, 4'd1, 4'd1, 4'd1};
    tick();
    i_rst_n = 1'b1;
  endtask

  function automatic logic [6:0] grant_word(input logic v, input int idx);
    logic [3:0] oh;
    oh = v ? (4'b0001 << idx) : 4'b0000;
    return {v, v ? 2'(idx) : 2'd0, oh};
  endfunction

  task automatic test_reset();
    i_rst_n       = 1'b0;
    bus.i_request = 4'b1111;
    bus.i_ack     = 1'b1;
    bus.i_weight  = {4'd1, 4'd1, 4'd1, 4'd1};
    tick();
    tick();
    n_cmp++;
    if (bus.o_grant_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid got=%b exp=0", bus.o_grant_valid);
    end
    n_cmp++;
    if (bus.o_grant_index !== 2'd0) begin
      n_err++; $display("FAIL reset_index got=%0d exp=0", bus.o_grant_index);
    end
    n_cmp++;
    if (bus.o_grant_onehot !== 4'b0000) begin
      n_err++; $display("FAIL reset_onehot got=%b exp=0000", bus.o_grant_onehot);
    end
  endtask

  task automatic test_rotation();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    logic [6:0] got;
    do_reset();
    bus.i_ack = 1'b1;
    tick();
    n_cmp++;
    if (bus.o_grant_valid !== 1'b0) begin
      n_err++; $display("FAIL rot_idle_ack got=%b exp=0", bus.o_grant_valid);
    end
    bus.i_request = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      got = {bus.o_grant_valid, bus.o_grant_index, bus.o_grant_onehot};
      n_cmp++;
      if (got !== grant_word(1'b1, exp_seq[k])) begin
        n_err++;
        $display("FAIL rot_step%0d got=%b exp=%b", k, got, grant_word(1'b1, exp_seq[k]));
      end
    end
  endtask

  task automatic test_weighted();
    int exp_seq [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    logic [6:0] got;
    do_reset();
    bus.i_weight  = {4'd1, 4'd1, 4'd1, 4'd3};
    bus.i_request = 4'b0011;
    bus.i_ack     = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      got = {bus.o_grant_valid, bus.o_grant_index, bus.o_grant_onehot};
      n_cmp++;
      if (got !== grant_word(1'b1, exp_seq[k])) begin
        n_err++;
        $display("FAIL wgt_step%0d got=%b exp=%b", k, got, grant_word(1'b1, exp_seq[k]));
      end
    end
  endtask

  task automatic test_hold();
    logic [6:0] got;
    int bad;
    do_reset();
    bus.i_weight  = {4'd1, 4'd5, 4'd1, 4'd1};
    bus.i_request = 4'b0100;
    tick();
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      got = {bus.o_grant_valid, bus.o_grant_index, bus.o_grant_onehot};
      if (got !== grant_word(1'b1, 2)) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL hold_stable bad_cycles=%0d exp=0 last=%b", bad, got);
    end
    bus.i_request = 4'b1100;
    bus.i_ack     = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      got = {bus.o_grant_valid, bus.o_grant_index, bus.o_grant_onehot};
      n_cmp++;
      if (got !== grant_word(1'b1, (k == 5) ? 3 : 2)) begin
        n_err++;
        $display("FAIL hold_ack%0d got=%b exp=%b", k, got, grant_word(1'b1, (k == 5) ? 3 : 2));
      end
    end
  endtask

  task automatic test_withdraw();
    logic [6:0] got;
    do_reset();
    bus.i_weight  = {4'd1, 4'd4, 4'd1, 4'd1};
    bus.i_request = 4'b0100;
    tick();
    tick();
    bus.i_request = 4'b1000;
    tick();
    got = {bus.o_grant_valid, bus.o_grant_index, bus.o_grant_onehot};
    n_cmp++;
    if (got !== grant_word(1'b1, 3)) begin
      n_err++; $display("FAIL withdraw_handoff got=%b exp=%b", got, grant_word(1'b1, 3));
    end
    bus.i_request = 4'b0000;
    tick();
    got = {bus.o_grant_valid, bus.o_grant_index, bus.o_grant_onehot};
    n_cmp++;
    if (got !== grant_word(1'b0, 0)) begin
      n_err++; $display("FAIL withdraw_idle got=%b exp=%b", got, grant_word(1'b0, 0));
    end
  endtask

  task automatic test_weight_zero();
    int exp_seq [5] = '{0, 1, 0, 1, 0};
    logic [6:0] got;
    do_reset();
    bus.i_weight  = {4'd1, 4'd1, 4'd0, 4'd1};
    bus.i_request = 4'b0011;
    bus.i_ack     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      got = {bus.o_grant_valid, bus.o_grant_index, bus.o_grant_onehot};
      n_cmp++;
      if (got !== grant_word(1'b1, exp_seq[k])) begin
        n_err++;
        $display("FAIL wzero_step%0d got=%b exp=%b", k, got, grant_word(1'b1, exp_seq[k]));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] got;
    do_reset();
    bus.i_weight  = {4'd5, 4'd5, 4'd5, 4'd5};
    bus.i_request = 4'b0100;
    tick();
    bus.i_ack = 1'b1;
    tick();
    tick();
    i_rst_n = 1'b0;
    tick();
    got = {bus.o_grant_valid, bus.o_grant_index, bus.o_grant_onehot};
    n_cmp++;
    if (got !== grant_word(1'b0, 0)) begin
      n_err++; $display("FAIL midrst_drop got=%b exp=%b", got, grant_word(1'b0, 0));
    end
    i_rst_n       = 1'b1;
    bus.i_ack     = 1'b0;
    bus.i_request = 4'b1010;
    tick();
    got = {bus.o_grant_valid, bus.o_grant_index, bus.o_grant_onehot};
    n_cmp++;
    if (got !== grant_word(1'b1, 1)) begin
      n_err++; $display("FAIL midrst_first got=%b exp=%b", got, grant_word(1'b1, 1));
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    i_rst_n       = 1'b0;
    bus.i_request = 4'b0000;
    bus.i_weight  = '0;
    bus.i_ack     = 1'b0;
    test_reset();
    test_rotation();
    test_weighted();
    test_hold();
    test_withdraw();
    test_weight_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
